ras_ctrl: RTL and testbench
===========================

RAS_CTRL -- requirements
Module: ras_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning return-stack entries (power of 2).
REQ-002 SHALL have parameter NCKPT, default 4, meaning checkpoint FIFO entries for unresolved control ops.
REQ-003 SHALL have port clk  in  1  single clock; all state rising-edge.
REQ-004 SHALL have port rst  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port fe_valid  in  1  fetch presents an op.
REQ-006 SHALL have port fe_ready  out  1  controller accepts op; transfer when fe_valid&fe_ready.
REQ-007 SHALL have port fe_opcode  in  7  rv32i_opcode of op.
REQ-008 SHALL have port fe_rs1 / fe_rd  in  5 each  register addresses.
REQ-009 SHALL have port fe_pc  in  32  op PC.
REQ-010 SHALL have port pred_valid  out  1  pred_target valid (pop with nonempty stack).
REQ-011 SHALL have port pred_target  out  32  predicted return address.
REQ-012 SHALL have port res_valid  in  1  oldest control op resolved (program order).
REQ-013 SHALL have port res_mispredict  in  1  qualifies res_valid; resolved op mispredicted.
REQ-014 SHALL have port ckpt_count  out  $clog2(NCKPT)+1  live checkpoints.

Function
REQ-015 SHALL classify link = reg in {x1,x5}; ctrl op = opcode in {op_jal, op_jalr, op_br}.
REQ-016 SHALL action: jal & link(rd) -> PUSH; jalr: !rd&!rs1 none, !rd&rs1 POP, rd&!rs1 PUSH, rd&rs1&rd!=rs1 POPPUSH, rd&rs1&rd==rs1 PUSH; all else none.
REQ-017 SHALL PUSH: stack[sp]<=fe_pc+4 (mod 2^32), sp<=sp+1 mod DEPTH, occ<=min(occ+1,DEPTH); full push overwrites oldest.
REQ-018 SHALL POP: if occ>0, pred_valid=1, pred_target=stack[sp-1 mod DEPTH], sp--, occ--; if occ==0, pred_valid=0, pred_target=0, no state change.
REQ-019 SHALL POPPUSH: pred_target=old stack[sp-1] (pred_valid=occ>0), then stack[sp-1]<=fe_pc+4, sp unchanged, occ<=max(occ,1).
REQ-020 SHALL drive pred_valid/pred_target combinationally in the accept cycle; 0 when no transfer or no pop.
REQ-021 SHALL on each accepted ctrl op enqueue checkpoint {sp, occ, stack[sp-1]} taken after the op's own action.
REQ-022 SHALL fe_ready = (state==RUN) & (ckpt_count<NCKPT) & !(res_valid&res_mispredict).
REQ-023 SHALL res_valid&!res_mispredict dequeue oldest checkpoint; with simultaneous accepted ctrl op, ckpt_count unchanged.
REQ-024 SHALL res_valid&res_mispredict: restore sp, occ, stack[sp-1]<=top from oldest checkpoint, clear all checkpoints, enter RECOVER.
REQ-025 SHALL FSM: RUN -(mispredict)-> RECOVER -(next clk)-> RUN; RECOVER holds fe_ready=0 for exactly 1 cycle.
REQ-026 SHALL ignore res_valid when ckpt_count==0 (no state change).
REQ-027 SHALL give mispredict priority over same-cycle fetch op (op not accepted).

Reset
REQ-028 SHALL on rst low, asynchronously: sp=0, occ=0, stack entries=0, ckpt_count=0, state=RUN, pred_valid=0, pred_target=0.
REQ-029 SHALL assert fe_ready=1 the first cycle after rst deasserts; reset mid-RECOVER returns to RUN.

Verification
REQ-030 SHALL test: jal x1 @0x100, then jalr x0,x1 -> pred_valid=1, pred_target=0x104, occ back to 0.
REQ-031 SHALL test: 9 pushes @0x0,0x10..0x80 then 9 pops -> targets 0x84..0x14, 9th pop pred_valid=0.
REQ-032 SHALL test: jalr x5,x1 @0x200 after push 0x104 -> pred_target=0x104, top becomes 0x204, occ unchanged.
REQ-033 SHALL test: 4 unresolved ctrl ops -> fe_ready=0; res_valid correct -> fe_ready=1, ckpt_count=3.
REQ-034 SHALL test: push 0x104 (ckpt), wrong-path pop+push 0x304, mispredict -> next pop yields 0x104; fe_ready=0 1 cycle.
REQ-035 SHALL test: rst low during RECOVER -> all outputs reset values immediately, fe_ready=1 after release.

Source files
------------

// File: rtl/ras_ctrl.sv
// ras_ctrl: return-address-stack controller for a fetch pipeline.
// Jal/jalr ops push or pop a circular return stack, and the popped top
// is offered to fetch as the predicted return target. Every accepted
// control op leaves a checkpoint of the stack pointer, occupancy and top
// entry. A mispredicted resolution rolls the stack back to the oldest
// checkpoint and stalls fetch for one cycle.
module ras_ctrl #(
  parameter int DEPTH = 8,
  parameter int NCKPT = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     fe_valid,
  output logic                     fe_ready,
  input  logic [6:0]               fe_opcode,
  input  logic [4:0]               fe_rs1,
  input  logic [4:0]               fe_rd,
  input  logic [31:0]              fe_pc,
  output logic                     pred_valid,
  output logic [31:0]              pred_target,
  input  logic                     res_valid,
  input  logic                     res_mispredict,
  output logic [$clog2(NCKPT):0]   ckpt_count
);

  localparam int SPW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OCW  = SPW + 1;
  localparam int CPW  = (NCKPT > 1) ? $clog2(NCKPT) : 1;
  localparam int CNTW = $clog2(NCKPT) + 1;

  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_BR   = 7'b1100011;

  localparam logic [SPW-1:0]  SP_ONE   = SPW'(1);
  localparam logic [OCW-1:0]  OCC_ONE  = OCW'(1);
  localparam logic [OCW-1:0]  OCC_FULL = OCW'(DEPTH);
  localparam logic [CNTW-1:0] CNT_ONE  = CNTW'(1);
  localparam logic [CNTW-1:0] CNT_FULL = CNTW'(NCKPT);
  localparam logic [CPW-1:0]  PTR_ONE  = CPW'(1);
  localparam logic [CPW-1:0]  PTR_LAST = CPW'(NCKPT - 1);

  typedef enum logic {
    ST_RUN,
    ST_RECOVER
  } state_e;

  typedef struct packed {
    logic [SPW-1:0] sp;
    logic [OCW-1:0] occ;
    logic [31:0]    top;
  } ckpt_t;

  state_e         state_q, state_d;
  logic [SPW-1:0] sp_q, sp_d;
  logic [OCW-1:0] occ_q, occ_d;
  logic [31:0]    stack_q [DEPTH];
  logic [31:0]    stack_d [DEPTH];
  ckpt_t          ck_q [NCKPT];
  ckpt_t          ck_d [NCKPT];
  logic [CPW-1:0] ck_head_q, ck_head_d;
  logic [CPW-1:0] ck_tail_q, ck_tail_d;
  logic [CNTW-1:0] ck_cnt_q, ck_cnt_d;

  logic           rd_link, rs1_link;
  logic           is_jal, is_jalr, is_br, is_ctrl;
  logic           do_push, do_pop, do_poppush;
  logic           mispredict, accept, occ_nz, res_live;
  logic           enq, deq;
  logic [SPW-1:0] top_idx, new_top_idx;
  logic [31:0]    ret_addr;
  ckpt_t          ck_oldest;

  function automatic logic [CPW-1:0] ptr_inc(input logic [CPW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_ONE;
  endfunction

  // Decode the fetched op into its stack action and form the handshake
  // and the combinational prediction for the accept cycle.
  always_comb begin
    rd_link    = (fe_rd == 5'd1) || (fe_rd == 5'd5);
    rs1_link   = (fe_rs1 == 5'd1) || (fe_rs1 == 5'd5);
    is_jal     = (fe_opcode == OP_JAL);
    is_jalr    = (fe_opcode == OP_JALR);
    is_br      = (fe_opcode == OP_BR);
    is_ctrl    = is_jal || is_jalr || is_br;
    do_push    = (is_jal && rd_link) ||
                 (is_jalr && rd_link && (!rs1_link || (fe_rd == fe_rs1)));
    do_pop     = is_jalr && !rd_link && rs1_link;
    do_poppush = is_jalr && rd_link && rs1_link && (fe_rd != fe_rs1);
    mispredict = res_valid && res_mispredict;
    fe_ready   = rst && (state_q == ST_RUN) && (ck_cnt_q < CNT_FULL) && !mispredict;
    accept     = fe_valid && fe_ready;
    occ_nz     = (occ_q != '0);
    top_idx    = sp_q - SP_ONE;
    ret_addr   = fe_pc + 32'd4;
    pred_valid = accept && (do_pop || do_poppush) && occ_nz;
    pred_target = pred_valid ? stack_q[top_idx] : 32'd0;
    ckpt_count = ck_cnt_q;
    res_live   = res_valid && (ck_cnt_q != '0);
    ck_oldest  = ck_q[ck_head_q];
  end

  // Next-state: apply the op's stack action, snapshot it into the
  // checkpoint FIFO, then let a live resolution retire or roll back.
  always_comb begin
    state_d     = (state_q == ST_RECOVER) ? ST_RUN : state_q;
    sp_d        = sp_q;
    occ_d       = occ_q;
    stack_d     = stack_q;
    ck_d        = ck_q;
    ck_head_d   = ck_head_q;
    ck_tail_d   = ck_tail_q;
    ck_cnt_d    = ck_cnt_q;
    new_top_idx = '0;
    enq         = 1'b0;
    deq         = 1'b0;

    if (accept) begin
      if (do_push) begin
        stack_d[sp_q] = ret_addr;
        sp_d          = sp_q + SP_ONE;
        occ_d         = (occ_q == OCC_FULL) ? occ_q : occ_q + OCC_ONE;
      end else if (do_pop && occ_nz) begin
        sp_d  = sp_q - SP_ONE;
        occ_d = occ_q - OCC_ONE;
      end else if (do_poppush) begin
        stack_d[top_idx] = ret_addr;
        occ_d            = occ_nz ? occ_q : OCC_ONE;
      end
      if (is_ctrl) begin
        enq                 = 1'b1;
        new_top_idx         = sp_d - SP_ONE;
        ck_d[ck_tail_q].sp  = sp_d;
        ck_d[ck_tail_q].occ = occ_d;
        ck_d[ck_tail_q].top = stack_d[new_top_idx];
        ck_tail_d           = ptr_inc(ck_tail_q);
      end
    end

    if (res_live && res_mispredict) begin
      sp_d    = ck_oldest.sp;
      occ_d   = ck_oldest.occ;
      stack_d[ck_oldest.sp - SP_ONE] = ck_oldest.top;
      ck_head_d = '0;
      ck_tail_d = '0;
      ck_cnt_d  = '0;
      state_d   = ST_RECOVER;
    end else begin
      deq = res_live;
      if (deq) begin
        ck_head_d = ptr_inc(ck_head_q);
      end
      if (enq && !deq) begin
        ck_cnt_d = ck_cnt_q + CNT_ONE;
      end else if (deq && !enq) begin
        ck_cnt_d = ck_cnt_q - CNT_ONE;
      end
    end
  end

  // State registers, cleared asynchronously while rst is low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_RUN;
      sp_q      <= '0;
      occ_q     <= '0;
      ck_head_q <= '0;
      ck_tail_q <= '0;
      ck_cnt_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        stack_q[i] <= '0;
      end
      for (int i = 0; i < NCKPT; i++) begin
        ck_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      sp_q      <= sp_d;
      occ_q     <= occ_d;
      ck_head_q <= ck_head_d;
      ck_tail_q <= ck_tail_d;
      ck_cnt_q  <= ck_cnt_d;
      stack_q   <= stack_d;
      ck_q      <= ck_d;
    end
  end

endmodule

// File: tb/tb_ras_ctrl.sv
// tb_ras_ctrl: scoreboard bench for ras_ctrl. A driver issues one cycle
// of stimulus at a time, predicts the response from a reference model of
// the return stack and pushes it into a queue; a monitor pops and
// compares on every falling edge.
module tb_ras_ctrl;

  localparam int DEPTH = 8;
  localparam int NCKPT = 4;

  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_ALU  = 7'b0010011;

  logic        clk;
  logic        rst;
  logic        fe_valid;
  logic        fe_ready;
  logic [6:0]  fe_opcode;
  logic [4:0]  fe_rs1;
  logic [4:0]  fe_rd;
  logic [31:0] fe_pc;
  logic        pred_valid;
  logic [31:0] pred_target;
  logic        res_valid;
  logic        res_mispredict;
  logic [$clog2(NCKPT):0] ckpt_count;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    bit          ready;
    bit          pv;
    logic [31:0] pt;
    int          cnt;
  } exp_t;

  typedef struct {
    int          sp;
    int          occ;
    logic [31:0] top;
  } mck_t;

  exp_t        exp_q[$];
  mck_t        m_ck[$];
  logic [31:0] m_stack [DEPTH];
  int          m_sp;
  int          m_occ;
  bit          m_run;

  ras_ctrl #(.DEPTH(DEPTH), .NCKPT(NCKPT)) dut (
    .clk            (clk),
    .rst            (rst),
    .fe_valid       (fe_valid),
    .fe_ready       (fe_ready),
    .fe_opcode      (fe_opcode),
    .fe_rs1         (fe_rs1),
    .fe_rd          (fe_rd),
    .fe_pc          (fe_pc),
    .pred_valid     (pred_valid),
    .pred_target    (pred_target),
    .res_valid      (res_valid),
    .res_mispredict (res_mispredict),
    .ckpt_count     (ckpt_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < DEPTH; i++) m_stack[i] = 32'd0;
    m_sp  = 0;
    m_occ = 0;
    m_run = 1'b1;
    m_ck.delete();
  endfunction

  function automatic bit is_link(input logic [4:0] r);
    return (r == 5'd1) || (r == 5'd5);
  endfunction

  // 0 none, 1 push, 2 pop, 3 pop-then-push
  function automatic int classify(input logic [6:0] opc, input logic [4:0] rd, input logic [4:0] rs1);
    if (opc == OP_JAL) return is_link(rd) ? 1 : 0;
    if (opc != OP_JALR) return 0;
    if (!is_link(rd) && !is_link(rs1)) return 0;
    if (!is_link(rd)) return 2;
    if (!is_link(rs1) || rd == rs1) return 1;
    return 3;
  endfunction

  // One cycle: drive inputs just after the rising edge, predict the
  // response, queue it for the monitor, and advance the model.
  task automatic applyStimulus(input bit v, input logic [6:0] opc, input logic [4:0] rd,
                               input logic [4:0] rs1, input logic [31:0] pc,
                               input bit rv, input bit rm);
    exp_t e;
    int   n_pre;
    int   act;
    int   ti;
    bit   acc;
    bit   live_mis;
    @(posedge clk);
    #1;
    fe_valid = v; fe_opcode = opc; fe_rd = rd; fe_rs1 = rs1; fe_pc = pc;
    res_valid = rv; res_mispredict = rm;
    n_pre   = m_ck.size();
    e.ready = m_run && (n_pre < NCKPT) && !(rv && rm);
    e.cnt   = n_pre;
    e.pv    = 1'b0;
    e.pt    = 32'd0;
    acc     = v && e.ready;
    if (acc) begin
      act = classify(opc, rd, rs1);
      ti  = (m_sp + DEPTH - 1) % DEPTH;
      if (act == 1) begin
        m_stack[m_sp] = pc + 32'd4;
        m_sp  = (m_sp + 1) % DEPTH;
        m_occ = (m_occ < DEPTH) ? m_occ + 1 : DEPTH;
      end else if (act == 2 && m_occ > 0) begin
        e.pv  = 1'b1;
        e.pt  = m_stack[ti];
        m_sp  = ti;
        m_occ = m_occ - 1;
      end else if (act == 3) begin
        if (m_occ > 0) begin
          e.pv = 1'b1;
          e.pt = m_stack[ti];
        end
        m_stack[ti] = pc + 32'd4;
        m_occ = (m_occ > 0) ? m_occ : 1;
      end
      if (opc == OP_JAL || opc == OP_JALR || opc == OP_BR)
        m_ck.push_back('{m_sp, m_occ, m_stack[(m_sp + DEPTH - 1) % DEPTH]});
    end
    live_mis = rv && rm && (n_pre > 0);
    if (live_mis) begin
      m_sp  = m_ck[0].sp;
      m_occ = m_ck[0].occ;
      m_stack[(m_ck[0].sp + DEPTH - 1) % DEPTH] = m_ck[0].top;
      m_ck.delete();
    end else if (rv && n_pre > 0) begin
      void'(m_ck.pop_front());
    end
    m_run = !live_mis;
    exp_q.push_back(e);
    #2;
  endtask

  task automatic op(input logic [6:0] opc, input logic [4:0] rd, input logic [4:0] rs1,
                    input logic [31:0] pc, input bit rv);
    applyStimulus(1'b1, opc, rd, rs1, pc, rv, 1'b0);
  endtask

  task automatic idle(input bit rv, input bit rm);
    applyStimulus(1'b0, OP_ALU, 5'd0, 5'd0, 32'd0, rv, rm);
  endtask

  task automatic drain();
    for (int i = 0; i < NCKPT + 2 && m_ck.size() > 0; i++) idle(1'b1, 1'b0);
  endtask

  function automatic logic [4:0] pick_reg();
    int k;
    k = $urandom_range(0, 3);
    if (k == 0) return 5'd0;
    if (k == 1) return 5'd1;
    if (k == 2) return 5'd5;
    return 5'($urandom_range(0, 31));
  endfunction

  // Monitor: compare every queued expectation against the DUT mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checkOutput("sb_fe_ready", 32'(fe_ready), 32'(e.ready));
      checkOutput("sb_pred_valid", 32'(pred_valid), 32'(e.pv));
      checkOutput("sb_pred_target", pred_target, e.pt);
      checkOutput("sb_ckpt_count", 32'(ckpt_count), 32'(e.cnt));
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [6:0] opc;
    bit         v, rv, rm;
    int         k;

    rst = 1'b0; fe_valid = 1'b0; fe_opcode = OP_ALU; fe_rd = '0; fe_rs1 = '0;
    fe_pc = '0; res_valid = 1'b0; res_mispredict = 1'b0;
    model_reset();
    #3;
    checkOutput("rst_pred_valid", 32'(pred_valid), 32'd0);
    checkOutput("rst_pred_target", pred_target, 32'd0);
    checkOutput("rst_ckpt_count", 32'(ckpt_count), 32'd0);
    #9 rst = 1'b1;
    #1 checkOutput("post_rst_ready", 32'(fe_ready), 32'd1);

    // jal x1 @0x100 then jalr x0,x1 predicts 0x104 and empties the stack
    op(OP_JAL, 5'd1, 5'd0, 32'h100, 1'b0);
    op(OP_JALR, 5'd0, 5'd1, 32'h110, 1'b0);
    checkOutput("pop_valid", 32'(pred_valid), 32'd1);
    checkOutput("pop_target", pred_target, 32'h104);
    op(OP_JALR, 5'd0, 5'd1, 32'h120, 1'b0);
    checkOutput("empty_pop_valid", 32'(pred_valid), 32'd0);
    checkOutput("empty_pop_target", pred_target, 32'd0);
    drain();

    // nine pushes overflow the 8-deep stack; pops return newest first
    for (int i = 0; i < 9; i++) op(OP_JAL, 5'd1, 5'd0, 32'(i * 16), 1'b1);
    for (int i = 0; i < 9; i++) begin
      op(OP_JALR, 5'd0, 5'd1, 32'h400, 1'b1);
      if (i < 8) begin
        checkOutput("ovf_pop_valid", 32'(pred_valid), 32'd1);
        checkOutput("ovf_pop_target", pred_target, 32'h84 - 32'(i * 16));
      end else begin
        checkOutput("ovf_ninth_pop_valid", 32'(pred_valid), 32'd0);
      end
    end
    drain();

    // jalr x5,x1 swaps the top entry without changing occupancy
    op(OP_JAL, 5'd1, 5'd0, 32'h100, 1'b1);
    op(OP_JALR, 5'd5, 5'd1, 32'h200, 1'b1);
    checkOutput("poppush_target", pred_target, 32'h104);
    op(OP_JALR, 5'd0, 5'd5, 32'h210, 1'b1);
    checkOutput("poppush_new_top", pred_target, 32'h204);
    op(OP_JALR, 5'd0, 5'd1, 32'h220, 1'b1);
    checkOutput("poppush_occ_one", 32'(pred_valid), 32'd0);
    drain();

    // four unresolved branches fill the checkpoint FIFO
    for (int i = 0; i < 4; i++) op(OP_BR, 5'd0, 5'd0, 32'h500 + 32'(i * 4), 1'b0);
    op(OP_BR, 5'd0, 5'd0, 32'h510, 1'b0);
    checkOutput("ckpt_full_ready", 32'(fe_ready), 32'd0);
    idle(1'b1, 1'b0);
    idle(1'b0, 1'b0);
    checkOutput("ckpt_freed_ready", 32'(fe_ready), 32'd1);
    checkOutput("ckpt_freed_count", 32'(ckpt_count), 32'd3);
    drain();

    // wrong-path pop+push is undone by a mispredict on the first push
    op(OP_JAL, 5'd1, 5'd0, 32'h100, 1'b0);
    op(OP_JALR, 5'd0, 5'd1, 32'h110, 1'b0);
    op(OP_JAL, 5'd1, 5'd0, 32'h300, 1'b0);
    idle(1'b1, 1'b1);
    checkOutput("mis_cycle_ready", 32'(fe_ready), 32'd0);
    op(OP_JALR, 5'd0, 5'd1, 32'h600, 1'b0);
    checkOutput("recover_ready", 32'(fe_ready), 32'd0);
    checkOutput("recover_count", 32'(ckpt_count), 32'd0);
    op(OP_JALR, 5'd0, 5'd1, 32'h600, 1'b0);
    checkOutput("restored_ready", 32'(fe_ready), 32'd1);
    checkOutput("restored_target", pred_target, 32'h104);
    drain();

    // reset asserted during RECOVER clears everything at once
    op(OP_JAL, 5'd1, 5'd0, 32'h700, 1'b0);
    idle(1'b1, 1'b1);
    idle(1'b0, 1'b0);
    @(negedge clk);
    #1;
    fe_valid = 1'b1; fe_opcode = OP_JALR; fe_rd = 5'd0; fe_rs1 = 5'd1;
    rst = 1'b0;
    #1;
    checkOutput("midrec_rst_valid", 32'(pred_valid), 32'd0);
    checkOutput("midrec_rst_target", pred_target, 32'd0);
    checkOutput("midrec_rst_count", 32'(ckpt_count), 32'd0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    fe_valid = 1'b0;
    rst = 1'b1;
    idle(1'b0, 1'b0);
    checkOutput("midrec_release_ready", 32'(fe_ready), 32'd1);

    // randomized traffic against the reference model
    for (int i = 0; i < 2000; i++) begin
      k = $urandom_range(0, 9);
      if (k < 3)      opc = OP_JAL;
      else if (k < 7) opc = OP_JALR;
      else if (k < 8) opc = OP_BR;
      else            opc = OP_ALU;
      v  = ($urandom_range(0, 3) != 0);
      rv = ($urandom_range(0, 2) == 0);
      rm = rv && ($urandom_range(0, 7) == 0);
      applyStimulus(v, opc, pick_reg(), pick_reg(), 32'($urandom()) & 32'hFFFF_FFFC, rv, rm);
    end

    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
